// File: rtl/asym_fifo_pkg.sv
// asym_fifo_pkg
// Shared types and helpers for the narrow-write / wide-read flush FIFO:
//   flush_st_e      flush sequencer states
//   min_slots()     slots taken by one read: min(remaining, ratio)
//   ERR_* indices   bit positions of the optional sticky error vector
//                   (only used when ASYM_FLUSH_FIFO_ERR_EN is defined)
package asym_fifo_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} flush_st_e;

  localparam int ERR_W           = 3;
  localparam int ERR_WR_FULL     = 0;
  localparam int ERR_RD_INVALID  = 1;
  localparam int ERR_FLUSH_EMPTY = 2;

  function automatic int unsigned min_slots(input int unsigned rem,
                                            input int unsigned ratio);
    return (rem < ratio) ? rem : ratio;
  endfunction

endpackage

// File: rtl/asym_fifo_gather.sv
// asym_fifo_gather
// Combinational read-word assembly. Word slot k is ring slot
// (rd_ptr + k) mod SLOTS, oldest slot in the LSBs; slots at k >= n read as 0.
// Ports:
//   slots_i    flattened slot ring, slot s at bits [s*WR_W +: WR_W]
//   rd_ptr_i   ring index of the oldest unread slot
//   n_i        number of live slots in this word (0..RATIO)
//   rd_data_o  assembled, zero-padded read word
//   rd_pad_o   RATIO - n_i
module asym_fifo_gather #(
  parameter int WR_W  = 4,
  parameter int RATIO = 8,
  parameter int SLOTS = 32,
  localparam int AW   = $clog2(SLOTS),
  localparam int PADW = $clog2(RATIO) + 1
) (
  input  logic [SLOTS*WR_W-1:0]  slots_i,
  input  logic [AW-1:0]          rd_ptr_i,
  input  logic [PADW-1:0]        n_i,
  output logic [RATIO*WR_W-1:0]  rd_data_o,
  output logic [PADW-1:0]        rd_pad_o
);

  for (genvar k = 0; k < RATIO; k++) begin : g_slot
    logic [AW-1:0] idx;
    // AW-bit addition wraps the gather across the top of the ring for free
    assign idx = rd_ptr_i + AW'(k);
    assign rd_data_o[k*WR_W +: WR_W] =
      (PADW'(k) < n_i) ? slots_i[idx*WR_W +: WR_W] : '0;
  end

  assign rd_pad_o = PADW'(RATIO) - n_i;

endmodule

// File: rtl/asym_flush_fifo.sv
// asym_flush_fifo
// Narrow-write / wide-read FIFO with flush. Storage is a ring of WR_W-bit
// slots; a read returns up to RATIO slots. A flush drains every slot written
// up to and including the request cycle, zero-padding the last word, while
// new writes keep landing behind the flush mark.
// Optional macro ASYM_FLUSH_FIFO_ERR_EN adds the sticky err_o vector and
// drops illegal writes/reads.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   wr_i, wr_data_i     write strobe and slot data
//   full_o, empty_o     count == SLOTS / count == 0
//   rd_i                read strobe (only while vld_rd_data_o)
//   rd_data_o           read word, valid combinationally
//   vld_rd_data_o       a read may be issued this cycle
//   rd_pad_o            zero-padded slots in rd_data_o
//   flush_req_i         flush request, held until flush_done_o
//   flush_done_o        one-cycle flush-complete pulse
//   err_o               (macro only) sticky protocol errors
//
// state | meaning
// IDLE  | normal operation, reads need RATIO slots
// FLUSH | draining up to mark_q, partial last word allowed
// DONE  | flush complete, flush_done_o high for this cycle
module asym_flush_fifo
  import asym_fifo_pkg::*;
#(
  parameter int WR_W     = 4,
  parameter int RD_W     = 32,
  parameter int CAP_BITS = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_i,
  input  logic [WR_W-1:0]               wr_data_i,
  output logic                          full_o,
  input  logic                          rd_i,
  output logic [RD_W-1:0]               rd_data_o,
  output logic                          vld_rd_data_o,
  output logic [$clog2(RD_W/WR_W):0]    rd_pad_o,
  output logic                          empty_o,
  input  logic                          flush_req_i,
  output logic                          flush_done_o
`ifdef ASYM_FLUSH_FIFO_ERR_EN
  ,
  output logic [ERR_W-1:0]              err_o
`endif
);

  localparam int RATIO = RD_W / WR_W;
  localparam int SLOTS = CAP_BITS / WR_W;
  localparam int PW    = $clog2(SLOTS) + 1;
  localparam int AW    = PW - 1;
  localparam int PADW  = $clog2(RATIO) + 1;

  if (RD_W % WR_W != 0) begin : g_bad_ratio
    $error("asym_flush_fifo: RD_W must be a multiple of WR_W");
  end
  if (CAP_BITS % RD_W != 0) begin : g_bad_cap
    $error("asym_flush_fifo: CAP_BITS must be a multiple of RD_W");
  end
  if ((SLOTS & (SLOTS - 1)) != 0) begin : g_bad_slots
    $error("asym_flush_fifo: CAP_BITS/WR_W must be a power of two");
  end

  logic [WR_W-1:0]       mem_q [SLOTS];
  logic [SLOTS*WR_W-1:0] mem_flat;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] mark_q, mark_d;
  logic [PW-1:0] count, rem, rem_after;
  flush_st_e     state_q, state_d;

  logic            wr_fire, rd_fire, vld, in_flush;
  logic [PADW-1:0] n_slots, gath_pad;
  logic [RD_W-1:0] gath_data;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign rem     = mark_q - rd_ptr_q;
  assign full_o  = (count == PW'(SLOTS));
  assign empty_o = (count == '0);

  // While flushing only slots below the mark are visible, even if more
  // than a word has been written since the request.
  assign in_flush = (state_q == FLUSH);
  assign vld      = in_flush ? (rem != '0) : (count >= PW'(RATIO));
  assign n_slots  = in_flush ? PADW'(min_slots(32'(rem), 32'(RATIO)))
                             : PADW'(RATIO);

`ifdef ASYM_FLUSH_FIFO_ERR_EN
  logic             flush_req_q;
  logic [ERR_W-1:0] err_q;

  assign wr_fire = wr_i & ~full_o;
  assign rd_fire = rd_i & vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q       <= '0;
      flush_req_q <= 1'b0;
    end else begin
      flush_req_q <= flush_req_i;
      if (wr_i && full_o)                          err_q[ERR_WR_FULL]     <= 1'b1;
      if (rd_i && !vld)                            err_q[ERR_RD_INVALID]  <= 1'b1;
      if (flush_req_i && !flush_req_q && empty_o)  err_q[ERR_FLUSH_EMPTY] <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign wr_fire = wr_i;
  assign rd_fire = rd_i;
`endif

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_flat
    assign mem_flat[s*WR_W +: WR_W] = mem_q[s];
  end

  asym_fifo_gather #(
    .WR_W  (WR_W),
    .RATIO (RATIO),
    .SLOTS (SLOTS)
  ) u_gather (
    .slots_i   (mem_flat),
    .rd_ptr_i  (rd_ptr_q[AW-1:0]),
    .n_i       (n_slots),
    .rd_data_o (gath_data),
    .rd_pad_o  (gath_pad)
  );

  // Masking keeps the read port at zero whenever nothing is offered,
  // including straight out of reset when storage is uninitialised.
  assign rd_data_o     = vld ? gath_data : '0;
  assign rd_pad_o      = vld ? gath_pad  : '0;
  assign vld_rd_data_o = vld;

  assign wr_ptr_d  = wr_ptr_q + PW'(wr_fire);
  assign rd_ptr_d  = rd_ptr_q + (rd_fire ? PW'(n_slots) : '0);
  assign rem_after = rem - (rd_fire ? PW'(n_slots) : '0);

  always_comb begin
    state_d      = state_q;
    mark_d       = mark_q;
    flush_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          // a write in the request cycle belongs to the flush
          mark_d  = wr_ptr_q + PW'(wr_fire);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (rem_after == '0) state_d = DONE;
      end
      DONE: begin
        flush_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mark_q   <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mark_q   <= mark_d;
      state_q  <= state_d;
    end
  end

endmodule
